// File: rtl/fetch_queue_stage_if.sv
// Fetch stage bus: instruction-memory read port, decode handshake and execute redirect.
// master = fetch stage, slave = memory/decode/execute side.
interface fetch_queue_stage_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: PC-driven memory read feeding a small {pc, inst} FIFO to decode.
// Optional FETCH_STATS_EN adds fetch_count/stall_count performance counters.
module fetch_queue_stage #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_queue_stage_if.master  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   pc_q;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rptr_q, wptr_q;
    logic          valid_q;
    logic [15:0]   fifo_inst_q [DEPTH];
    logic [15:0]   fifo_pc_q   [DEPTH];
    logic          push, pop;

    always_comb begin
        pop  = valid_q & bus.out_ready;
        // Full FIFO may still accept when the head leaves in the same cycle.
        push = ~bus.redirect_valid & ((count_q != CW'(DEPTH)) | pop);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_pc;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                pc_q   <= pc_q + 16'd1;
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_inst_q[wptr_q] <= bus.imem_data;
            fifo_pc_q[wptr_q]   <= pc_q;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.out_inst  = fifo_inst_q[rptr_q];
    assign bus.out_pc    = fifo_pc_q[rptr_q];

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (valid_q && !bus.out_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus random traffic against a queue-based model.
// Counter checks are enabled when FETCH_STATS_EN is defined.
module tb_fetch_queue_stage;
    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    fetch_queue_stage_if bus ();
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif

    fetch_queue_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    assign bus.imem_data = mem[bus.imem_addr];

    // Reference model: queue of {pc, inst}, fetch address, counters.
    logic [31:0] mq [$];
    logic [15:0] m_pc;
    logic [31:0] m_fetch, m_stall;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(bus.out_pc), 32'(mq[0][31:16]));
            chk("out_inst", 32'(bus.out_inst), 32'(mq[0][15:0]));
        end
`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, m_fetch);
        chk("stall_count", stall_count, m_stall);
`endif
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input logic r, input logic rdv, input logic [15:0] rpc, input logic rdy);
        bit vld, pop, push;
        rst                = r;
        bus.redirect_valid = rdv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        vld  = (mq.size() != 0);
        pop  = vld && rdy;
        push = !rdv && ((mq.size() < DEPTH) || pop);
        if (r) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_fetch = 0;
            m_stall = 0;
        end else begin
            if (vld && !rdy) m_stall++;
            if (rdv) begin
                mq.delete();
                m_pc = rpc;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back({m_pc, mem[m_pc]});
                    m_pc = m_pc + 16'd1;
                    m_fetch++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [15:0] exp_pc;
        for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 + 16'(i);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.out_ready      = 1'b0;
        m_pc = RESET_PC;
        m_fetch = 0;
        m_stall = 0;
        #1;

        // Reset then streaming with out_ready high.
        step(1, 0, 0, 1);
        chk("reset_valid", 32'(bus.out_valid), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
            chk("stream_pc", 32'(bus.out_pc), i);
            chk("stream_inst", 32'(bus.out_inst), 32'hA000 + i);
        end

        // Backpressure: six stalled cycles.
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("bp_addr_hold", 32'(bus.imem_addr), 32'h0002);
        chk("bp_head_pc", 32'(bus.out_pc), 0);
        chk("bp_head_inst", 32'(bus.out_inst), 32'hA000);

        // Redirect with two entries queued.
        step(0, 1, 16'h0100, 0);
        chk("rd_valid", 32'(bus.out_valid), 0);
        chk("rd_addr", 32'(bus.imem_addr), 32'h0100);
        step(0, 0, 0, 1);
        chk("rd_first_pc", 32'(bus.out_pc), 32'h0100);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // PC wrap.
        step(0, 1, 16'hFFFE, 1);
        exp_pc = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("wrap_pc", 32'(bus.out_pc), 32'(exp_pc));
            exp_pc = exp_pc + 16'd1;
        end

        // Full FIFO, then simultaneous push/pop each cycle, then mid-stream reset.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        exp_pc = bus.imem_addr;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            exp_pc = exp_pc + 16'd1;
            chk("full_pc_adv", 32'(bus.imem_addr), 32'(exp_pc));
        end
        step(1, 0, 0, 1);
        chk("midrst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        chk("midrst_valid", 32'(bus.out_valid), 0);

        // Back-to-back redirects: last one wins.
        step(0, 1, 16'h0300, 1);
        step(0, 1, 16'h0400, 1);
        step(0, 0, 0, 1);
        chk("b2b_pc", 32'(bus.out_pc), 32'h0400);

        // Self-modifying code: queued words stay stale, refetch after redirect sees the new word.
        step(0, 1, 16'h0200, 0);
        step(0, 0, 0, 0);
        mem[16'h0200] = 16'h1234;
        step(0, 0, 0, 0);
        chk("smc_stale", 32'(bus.out_inst), 32'hA200);
        step(0, 1, 16'h0200, 1);
        step(0, 0, 0, 1);
        chk("smc_new", 32'(bus.out_inst), 32'h1234);

`ifdef FETCH_STATS_EN
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("stats_fetch10", fetch_count, 10);
        chk("stats_stall3", stall_count, 3);
        step(0, 1, 16'h0050, 1);
        chk("stats_rd_fetch", fetch_count, 10);
        chk("stats_rd_stall", stall_count, 3);
        step(1, 0, 0, 1);
        chk("stats_rst_fetch", fetch_count, 0);
        chk("stats_rst_stall", stall_count, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0,
                 16'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch front end of the pipelined CPU; sits directly upstream of the dual-read-port program memory.
- Drives the memory's instruction read port (address out, combinational data in) from a program counter.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects from execute for branches, jumps and exceptions.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  16  instruction read address to memory port 0; equals pc
- imem_data  in  16  combinational read data from memory port 0 for imem_addr
- out_valid  out  1  head FIFO entry valid
- out_ready  in  1  decode accepts head entry this cycle
- out_inst  out  16  instruction word at FIFO head
- out_pc  out  16  address the head word was fetched from
- redirect_valid  in  1  flush and restart fetch this cycle
- redirect_pc  in  16  new fetch address when redirect_valid=1

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc<=RESET_PC; FIFO emptied (count=0, read and write pointers 0).
  - out_valid=0 from the next cycle; out_inst and out_pc are don't-care while out_valid=0.
  - Reset has priority over redirect and handshakes, including mid-stream with entries queued.
- pop: out_valid & out_ready.
- push: ~redirect_valid & (count<DEPTH | pop).
  - A simultaneous push and pop is allowed when the FIFO is full.
- Each push writes {pc, imem_data} at the write pointer, then pc<=pc+1.
  - PC arithmetic is 16-bit modulo: 16'hFFFF wraps to 16'h0000.
- No push leaves pc unchanged. imem_addr=pc continuously; the memory read is combinational.
- Latency: a word fetched in cycle N is presented (out_valid=1) in cycle N+1 at the earliest.
  - With out_ready held high, throughput is one instruction per cycle.
- count update:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- out_valid = (count!=0), driven directly from registered state.
  - out_inst and out_pc come from the head entry and are stable while out_valid=1 & out_ready=0.
- Redirect (redirect_valid=1, rst=0):
  - All entries discarded (count<=0, pointers reset).
  - pc<=redirect_pc; no push that cycle.
  - A pop in the same cycle is still considered consumed by decode; the flush then empties the FIFO.
  - Next cycle: out_valid=0, imem_addr=redirect_pc; that word is pushed and appears the cycle after.
  - Back-to-back redirects: the last one wins, and nothing is pushed during any redirect cycle.
- Empty FIFO with out_ready=1: no pop; out_ready is ignored.
- Full FIFO with out_ready=0: no push; pc holds; imem_addr stays stable.
- Self-modifying code: a memory write to address A at edge E is visible to a fetch of A in the cycle after E.
  - Words already queued are not updated; software issues a redirect to refetch.
- No combinational path from out_ready or redirect_valid to imem_addr. imem_addr is a register output.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, two extra output ports are added:
  - fetch_count (out, 32): increments on every push.
  - stall_count (out, 32): increments in each cycle where out_valid=1 & out_ready=0.
- Both counters clear on rst, are not cleared by redirect, and wrap modulo 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=16'h0000, memory[i]=16'hA000+i, out_ready=1:
  - Cycles 1..5 after reset show out_pc 0,1,2,3,4 with out_inst A000..A004.
  - out_valid is 0 in the first cycle after reset.
- Backpressure, DEPTH=2, out_ready=0 for 6 cycles:
  - count saturates at 2 and imem_addr holds at 16'h0002.
  - Head stays pc=0/A000.
  - Releasing out_ready yields pc 0,1,2 in order with no loss or duplication.
- Redirect to 16'h0100 while 2 entries are queued:
  - Next cycle out_valid=0 and imem_addr=16'h0100.
  - The following cycle out_pc=16'h0100.
  - No stale entries (pc 0..2) ever appear after the redirect.
- PC wrap: redirect to 16'hFFFE, out_ready=1:
  - Outputs show out_pc FFFE, FFFF, 0000, 0001.
- Full FIFO with simultaneous pop and push:
  - count stays 2 and pc advances by 1 per cycle.
  - Reset asserted mid-stream returns pc to RESET_PC and out_valid to 0 next cycle.
- With FETCH_STATS_EN, 10 pushes and 3 stall cycles:
  - fetch_count=10, stall_count=3.
  - A redirect leaves both counters unchanged; rst clears both to 0.
